// File: rtl/simple_uart_pkg.sv
// Shared constants, RX state encoding and the divider clamp for the console UART.
package simple_uart_pkg;

  localparam int          FRAME_BITS = 10;
  localparam int          DUMMY_BITS = 15;
  localparam logic [31:0] DIV_MIN    = 32'd2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Bit period actually used by both directions; tiny divisors are clamped.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

endpackage

// File: rtl/simple_uart_rx.sv
// RX path: input synchroniser, 8N1 deserialiser FSM and single-byte holding buffer.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits LSB first, one per bit period
// STOP  | sampling the stop bit; store byte only if it is 1
module simple_uart_rx
  import simple_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_rx,
  input  logic [31:0] div,
  input  logic        re,
  output logic        rx_valid,
  output logic [7:0]  rx_data
);

  logic        sync1, sync2, sync_prev;
  rx_state_t   state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] period;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  data_n;
  logic        valid_n;

  assign period = eff_div(div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      state     <= IDLE;
      cnt       <= 32'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
    end else begin
      sync1     <= ser_rx;
      sync2     <= sync1;
      sync_prev <= sync2;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
    end
  end

  // A byte completing in the same cycle as a read-acknowledge overrides the clear.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = rx_data;
    valid_n   = rx_valid && !re;
    case (state)
      IDLE: begin
        if (sync_prev && !sync2) begin
          state_n = START;
          cnt_n   = (period >> 1) - 32'd1;
        end
      end
      START: begin
        if (cnt == 32'd0) begin
          if (!sync2) begin
            state_n   = DATA;
            cnt_n     = period - 32'd1;
            bit_idx_n = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      DATA: begin
        if (cnt == 32'd0) begin
          shift_n = {sync2, shift[7:1]};
          cnt_n   = period - 32'd1;
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      STOP: begin
        if (cnt == 32'd0) begin
          state_n = IDLE;
          if (sync2) begin
            data_n  = shift;
            valid_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/simple_uart.sv
// Memory-mapped 8N1 console UART: divider register and TX shifter here, RX in simple_uart_rx.
module simple_uart
  import simple_uart_pkg::*;
#(
  parameter logic [31:0] DEFAULT_DIV = 32'd139
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);

  logic [31:0] div_q, div_n;
  logic [31:0] tx_cnt;
  logic [9:0]  tx_sr;
  logic [3:0]  tx_bits;
  logic        tx_armed;
  logic        tx_busy, tx_accept;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        unused_dat_hi;

  always_comb begin
    div_n = div_q;
    for (int i = 0; i < 4; i++)
      if (reg_div_we[i]) div_n[8*i +: 8] = reg_div_di[8*i +: 8];
  end

  // tx_armed forces the master to drop we before a second byte is taken.
  assign tx_busy      = (tx_bits != 4'd0);
  assign tx_accept    = reg_dat_we && !tx_busy && tx_armed;
  assign reg_dat_wait = reg_dat_we && tx_busy;
  assign ser_tx       = tx_sr[0];
  assign reg_div_do   = div_q;
  assign unused_dat_hi = ^reg_dat_di[31:8];

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      div_q    <= DEFAULT_DIV;
      tx_sr    <= '1;
      tx_bits  <= 4'(DUMMY_BITS);
      tx_cnt   <= eff_div(DEFAULT_DIV) - 32'd1;
      tx_armed <= 1'b1;
    end else begin
      div_q <= div_n;
      if (!reg_dat_we) tx_armed <= 1'b1;
      if (|reg_div_we) begin
        tx_sr   <= '1;
        tx_bits <= 4'(DUMMY_BITS);
        tx_cnt  <= eff_div(div_n) - 32'd1;
      end else if (tx_accept) begin
        tx_sr    <= {1'b1, reg_dat_di[7:0], 1'b0};
        tx_bits  <= 4'(FRAME_BITS);
        tx_cnt   <= eff_div(div_q) - 32'd1;
        tx_armed <= 1'b0;
      end else if (tx_busy) begin
        if (tx_cnt == 32'd0) begin
          tx_sr   <= {1'b1, tx_sr[9:1]};
          tx_bits <= tx_bits - 4'd1;
          tx_cnt  <= eff_div(div_q) - 32'd1;
        end else begin
          tx_cnt <= tx_cnt - 32'd1;
        end
      end
    end
  end

  simple_uart_rx u_rx (
    .clk      (clk),
    .rst      (resetn),
    .ser_rx   (ser_rx),
    .div      (div_q),
    .re       (reg_dat_re),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  assign reg_dat_do = rx_valid ? {24'h0, rx_data} : 32'h0000_0000;

endmodule

// File: tb/tb_simple_uart.sv
// Directed bench for simple_uart: register vector table plus hand-written TX/RX/reset sequences.
module tb_simple_uart;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        ser_tx;
  logic        ser_rx = 1'b1;
  logic [3:0]  reg_div_we = 4'h0;
  logic [31:0] reg_div_di = 32'h0;
  logic [31:0] reg_div_do;
  logic        reg_dat_we = 1'b0;
  logic        reg_dat_re = 1'b0;
  logic [31:0] reg_dat_di = 32'h0;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  simple_uart dut (
    .clk          (clk),
    .resetn       (resetn),
    .ser_tx       (ser_tx),
    .ser_rx       (ser_rx),
    .reg_div_we   (reg_div_we),
    .reg_div_di   (reg_div_di),
    .reg_div_do   (reg_div_do),
    .reg_dat_we   (reg_dat_we),
    .reg_dat_re   (reg_dat_re),
    .reg_dat_di   (reg_dat_di),
    .reg_dat_do   (reg_dat_do),
    .reg_dat_wait (reg_dat_wait)
  );

  typedef struct {
    logic [3:0]  div_we;
    logic [31:0] div_di;
    logic        dat_we;
    logic [31:0] exp_div;
    logic        exp_wait;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic write_div(input logic [3:0] we, input logic [31:0] di);
    reg_div_we = we;
    reg_div_di = di;
    @(negedge clk);
    reg_div_we = 4'h0;
  endtask

  // Counts negedges with wait high (we already driven); bounded.
  task automatic count_wait(output int n);
    n = 0;
    #1;
    while (reg_dat_wait && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  // Entered at the first negedge after the accept edge; drops we after one more cycle.
  task automatic tx_frame_chk(input logic [7:0] b, input int d, input string tag);
    logic [9:0] f;
    logic       ok;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < d; j++) begin
        chk($sformatf("%s_bit%0d", tag, i), {31'b0, ser_tx}, {31'b0, f[i]});
        @(negedge clk);
        reg_dat_we = 1'b0;
      end
    end
    chk($sformatf("%s_wait_after", tag), {31'b0, reg_dat_wait}, 32'd0);
    ok = 1'b1;
    repeat (8 * d) begin
      if (ser_tx !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("%s_no_second_frame", tag), {31'b0, ok}, 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_rx = f[i];
      repeat (8) @(negedge clk);
    end
    ser_rx = 1'b1;
  endtask

  task automatic pulse_re;
    reg_dat_re = 1'b1;
    @(negedge clk);
    reg_dat_re = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0] = '{4'h0, 32'h0000_0000, 1'b0, 32'd139,       1'b0};
    vecs[1] = '{4'hF, 32'h0000_0004, 1'b1, 32'd4,         1'b1};
    vecs[2] = '{4'h1, 32'h0000_1234, 1'b0, 32'h0000_0034, 1'b0};
    vecs[3] = '{4'h2, 32'h0000_1234, 1'b1, 32'h0000_1234, 1'b1};
    vecs[4] = '{4'hC, 32'hABCD_0000, 1'b0, 32'hABCD_1234, 1'b0};
    vecs[5] = '{4'h4, 32'h00EE_0000, 1'b1, 32'hABEE_1234, 1'b1};
    vecs[6] = '{4'hF, 32'h0000_0001, 1'b0, 32'd1,         1'b0};
    vecs[7] = '{4'h0, 32'h0000_0000, 1'b1, 32'd1,         1'b1};
    vecs[8] = '{4'hF, 32'h0000_0000, 1'b0, 32'd0,         1'b0};

    repeat (3) @(negedge clk);
    chk("rst_ser_tx", {31'b0, ser_tx}, 32'd1);
    chk("rst_div", reg_div_do, 32'd139);
    chk("rst_dat_do", reg_dat_do, 32'd0);
    resetn = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      reg_div_we = vecs[i].div_we;
      reg_div_di = vecs[i].div_di;
      reg_dat_we = vecs[i].dat_we;
      #1;
      chk($sformatf("vec%0d_wait", i), {31'b0, reg_dat_wait}, {31'b0, vecs[i].exp_wait});
      @(negedge clk);
      reg_div_we = 4'h0;
      reg_dat_we = 1'b0;
      chk($sformatf("vec%0d_div", i), reg_div_do, vecs[i].exp_div);
      chk($sformatf("vec%0d_tx", i), {31'b0, ser_tx}, 32'd1);
    end

    // div = 0 is clamped to 2: dummy frame 30 cycles, data frame 2 cycles/bit
    reg_dat_we = 1'b1;
    reg_dat_di = 32'h0000_00C3;
    count_wait(n);
    chk("dummy_len_div0", n, 32'd30);
    @(negedge clk);
    reg_dat_we = 1'b0;
    tx_frame_chk(8'hC3, 2, "txc3");

    write_div(4'hF, 32'd4);
    chk("div_4", reg_div_do, 32'd4);
    reg_dat_we = 1'b1;
    reg_dat_di = 32'hFFFF_FFA5;
    count_wait(n);
    chk("dummy_len_div4", n, 32'd60);
    @(negedge clk);
    chk("hold_we_wait", {31'b0, reg_dat_wait}, 32'd1);
    tx_frame_chk(8'hA5, 4, "txa5");

    write_div(4'hF, 32'd8);
    chk("div_8", reg_div_do, 32'd8);
    repeat (4) @(negedge clk);
    send_rx(8'h3C, 1'b1);
    chk("rx_3c", reg_dat_do, 32'h3C);
    pulse_re();
    chk("rx_re_clear", reg_dat_do, 32'h0);

    ser_rx = 1'b0;
    repeat (2) @(negedge clk);
    ser_rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("rx_glitch_no_byte", reg_dat_do, 32'h0);
    send_rx(8'h55, 1'b1);
    chk("rx_after_glitch", reg_dat_do, 32'h55);

    send_rx(8'h77, 1'b0);
    repeat (20) @(negedge clk);
    chk("rx_frame_err_kept", reg_dat_do, 32'h55);
    pulse_re();
    chk("rx_re_clear2", reg_dat_do, 32'h0);

    send_rx(8'h11, 1'b1);
    chk("rx_b2b_first", reg_dat_do, 32'h11);
    send_rx(8'h22, 1'b1);
    chk("rx_b2b_second", reg_dat_do, 32'h22);
    repeat (10) @(negedge clk);

    // reset in the middle of a TX frame of 0x00
    reg_dat_we = 1'b1;
    reg_dat_di = 32'h0;
    count_wait(n);
    chk("tx_idle_accept", n, 32'd0);
    @(negedge clk);
    reg_dat_we = 1'b0;
    repeat (10) @(negedge clk);
    chk("tx_mid_frame_low", {31'b0, ser_tx}, 32'd0);
    #2;
    resetn = 1'b1;
    #1;
    chk("rst_async_tx_high", {31'b0, ser_tx}, 32'd1);
    chk("rst_async_div", reg_div_do, 32'd139);
    chk("rst_async_rx_clear", reg_dat_do, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    reg_dat_we = 1'b1;
    reg_dat_di = 32'h0000_0042;
    count_wait(n);
    chk("dummy_len_after_reset", n, 32'd2085);
    @(negedge clk);
    reg_dat_we = 1'b0;
    chk("tx_start_after_reset", {31'b0, ser_tx}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
